text_buffer_ctrl: RTL and testbench
===================================

TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): COLS, 32, characters per row; ROWS, 32, rows in circular buffer; VIS_ROWS, 16, rows on screen; BLANK, 26, space glyph code.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk_in  input  1  single clock for all logic
  rst_in  input  1  synchronous, active-high reset
  char_valid_in  input  1  character strobe
  char_in  input  5  glyph 0-27; 28 newline; 29 backspace; 30 clear; 31 ignored
  char_ready_out  output  1  character accepted when valid and ready are both high
  scroll_req_in  input  2  1 = view newer (+1 row); 2 = view older (-1 row); 0/3 = none
  wr_en_out  output  1  text BRAM write strobe
  wr_addr_out  output  10  BRAM address = row*32 + col
  wr_data_out  output  5  glyph to write
  scroll_lines_out  output  5  top visible row, read mod 32 by the display
  cursor_row_out  output  5  current cursor row
  cursor_col_out  output  5  current cursor column
  busy_out  output  1  high in CLEAR or ROW_CLEAR

Function
REQ-003 The FSM SHALL have three states: IDLE, ROW_CLEAR, CLEAR; char_ready_out SHALL be high only in IDLE.
REQ-004 All outputs SHALL be registered; for an accepted character, the write SHALL appear on wr_* exactly one cycle after acceptance.
REQ-005 For a glyph (0-27), the block SHALL write it at (row,col), then col+1; if col was 31, col SHALL become 0, row SHALL become (row+1) mod 32, and the FSM SHALL enter ROW_CLEAR.
REQ-006 In IDLE, back-to-back glyphs that stay within a row SHALL be accepted one per cycle.
REQ-007 For a newline, the block SHALL issue no write, set col to 0, set row to (row+1) mod 32, and enter ROW_CLEAR.
REQ-008 For a backspace with col>0, the block SHALL decrement col and write BLANK at the new position; with col==0, it SHALL be a no-op with no write and no row retreat.
REQ-009 For a clear, the block SHALL enter CLEAR and set cursor (0,0) and scroll_lines_out to 0; code 31 SHALL be accepted and ignored.
REQ-010 ROW_CLEAR SHALL write BLANK to the 32 addresses of the new row, one per cycle, col ascending from 0, then return to IDLE; ready SHALL be low for exactly 32 cycles.
REQ-011 CLEAR SHALL write BLANK to addresses 0..1023, one per cycle, ascending, then return to IDLE; ready SHALL be low for exactly 1024 cycles.
REQ-012 Outside ROW_CLEAR and CLEAR, wr_en_out SHALL be low except for the single-cycle writes of REQ-005 and REQ-008.
REQ-013 Define dist = (cursor_row - scroll_lines) mod 32; on entering a new row, if dist > 15, scroll_lines SHALL become (row-15) mod 32 (auto-follow).
REQ-014 Any accepted glyph or backspace while dist > 15 SHALL first snap scroll_lines to (cursor_row-15) mod 32.
REQ-015 scroll_req_in SHALL act only in IDLE with no character accepted in that cycle; an accepted character SHALL win and the request SHALL be dropped.
REQ-016 Request 1 SHALL increment scroll_lines mod 32 only if dist > 15; request 2 SHALL decrement it mod 32 only if dist < 31; otherwise the request SHALL be ignored; scroll_lines SHALL change by at most one row per cycle.
REQ-017 Row and address arithmetic SHALL wrap modulo 32 and modulo 1024 respectively, with no saturation.

Reset
REQ-018 Reset SHALL set cursor to (0,0), scroll_lines_out to 0, wr_en_out to 0, and char_ready_out to 0, and enter CLEAR (REQ-011); busy_out SHALL be 1 in the first cycle after reset.
REQ-019 Reset asserted mid-ROW_CLEAR or mid-CLEAR SHALL abort the sweep and restart a full CLEAR from address 0.

Verification
REQ-020 After reset release: 1024 writes of 26 to addresses 0..1023, then ready=1, busy=0.
REQ-021 Glyphs 3,4,5 on consecutive cycles at (0,0): writes addr 0,1,2 with data 3,4,5 one cycle after each acceptance; ready stays high; cursor_col=3.
REQ-022 32 glyphs on row 0, then a newline: ROW_CLEAR writes addr 32..63 with data 26, then ROW_CLEAR writes addr 64..95 with data 26, ending at cursor (2,0).
REQ-023 16 newlines from reset: cursor_row=16, scroll_lines=1; scroll_req=2 gives scroll 0, then 31 (dist 17); scroll_req=1 twice returns scroll to 1; a further scroll_req=1 is ignored.
REQ-024 Backspace at (0,0): no write, cursor unchanged; at (0,5): write 26 to addr 4, col=4.
REQ-025 Clear code issued at cursor (31,7): 1024-cycle CLEAR, cursor (0,0), scroll 0; reset pulsed at CLEAR address 500: sweep restarts at address 0.

Source files
------------

// File: rtl/text_buffer_ctrl_if.sv
// Character/scroll request inputs and BRAM-write/cursor/status outputs of the
// text buffer controller, bundled so producer and controller share one port.
interface text_buffer_ctrl_if;
  logic       char_valid_in;
  logic [4:0] char_in;
  logic       char_ready_out;
  logic [1:0] scroll_req_in;
  logic       wr_en_out;
  logic [9:0] wr_addr_out;
  logic [4:0] wr_data_out;
  logic [4:0] scroll_lines_out;
  logic [4:0] cursor_row_out;
  logic [4:0] cursor_col_out;
  logic       busy_out;

  modport master (
    output char_valid_in, char_in, scroll_req_in,
    input  char_ready_out, wr_en_out, wr_addr_out, wr_data_out,
           scroll_lines_out, cursor_row_out, cursor_col_out, busy_out
  );

  modport slave (
    input  char_valid_in, char_in, scroll_req_in,
    output char_ready_out, wr_en_out, wr_addr_out, wr_data_out,
           scroll_lines_out, cursor_row_out, cursor_col_out, busy_out
  );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Text console write controller: turns a character stream into text-BRAM writes,
// tracks cursor and scrolled view, and blanks new rows or the whole screen.
module text_buffer_ctrl #(
  parameter int COLS     = 32,
  parameter int ROWS     = 32,
  parameter int VIS_ROWS = 16,
  parameter int BLANK    = 26
) (
  input  logic              clk_in,
  input  logic              rst_in,
  text_buffer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ROW_CLEAR,
    CLEAR
  } state_t;

  localparam logic [4:0] CH_LAST_GLYPH = 5'd27;
  localparam logic [4:0] CH_NEWLINE    = 5'd28;
  localparam logic [4:0] CH_BACKSPACE  = 5'd29;
  localparam logic [4:0] CH_CLEAR      = 5'd30;
  localparam logic [4:0] LAST_COL      = 5'(COLS - 1);
  localparam logic [4:0] FOLLOW_DIST   = 5'(VIS_ROWS - 1);
  localparam logic [4:0] MAX_DIST      = 5'(ROWS - 1);
  localparam logic [4:0] BLANK_GLYPH   = 5'(BLANK);
  localparam logic [9:0] ROW_LAST      = 10'(COLS - 1);
  localparam logic [9:0] LAST_ADDR     = 10'(COLS * ROWS - 1);
  localparam logic [1:0] REQ_NEWER     = 2'd1;
  localparam logic [1:0] REQ_OLDER     = 2'd2;

  state_t     state_q, state_d;
  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [4:0] scroll_q, scroll_d;
  logic [9:0] sweep_q, sweep_d;
  logic       wr_en_q, wr_en_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [4:0] wr_data_q, wr_data_d;
  logic       ready_q;
  logic       busy_q;

  logic [4:0] view_top;
  logic [4:0] next_row;
  logic [4:0] view_dist;

  // Top row that keeps `row` on the bottom visible line once it drops out of view.
  function automatic logic [4:0] follow(input logic [4:0] row, input logic [4:0] top);
    logic [4:0] d;
    d = row - top;
    return (d > FOLLOW_DIST) ? row - FOLLOW_DIST : top;
  endfunction

  always_comb begin
    // NOTE: every variable driven here gets a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    scroll_d  = scroll_q;
    sweep_d   = sweep_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    view_top  = follow(row_q, scroll_q);
    next_row  = row_q + 5'd1;
    view_dist = row_q - scroll_q;

    case (state_q)
      IDLE: begin
        if (bus.char_valid_in) begin
          if (bus.char_in <= CH_LAST_GLYPH) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {row_q, col_q};
            wr_data_d = bus.char_in;
            scroll_d  = view_top;
            if (col_q == LAST_COL) begin
              col_d    = '0;
              row_d    = next_row;
              scroll_d = follow(next_row, view_top);
              sweep_d  = '0;
              state_d  = ROW_CLEAR;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else begin
            case (bus.char_in)
              CH_NEWLINE: begin
                col_d    = '0;
                row_d    = next_row;
                scroll_d = follow(next_row, scroll_q);
                sweep_d  = '0;
                state_d  = ROW_CLEAR;
              end
              CH_BACKSPACE: begin
                scroll_d = view_top;
                // Backspace never retreats into the previous row.
                if (col_q != '0) begin
                  col_d     = col_q - 5'd1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {row_q, col_q - 5'd1};
                  wr_data_d = BLANK_GLYPH;
                end
              end
              CH_CLEAR: begin
                row_d    = '0;
                col_d    = '0;
                scroll_d = '0;
                sweep_d  = '0;
                state_d  = CLEAR;
              end
              default: ;
            endcase
          end
        end else if (bus.scroll_req_in == REQ_NEWER) begin
          if (view_dist > FOLLOW_DIST) scroll_d = scroll_q + 5'd1;
        end else if (bus.scroll_req_in == REQ_OLDER) begin
          if (view_dist < MAX_DIST) scroll_d = scroll_q - 5'd1;
        end
      end

      ROW_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {row_q, sweep_q[4:0]};
        wr_data_d = BLANK_GLYPH;
        if (sweep_q == ROW_LAST) state_d = IDLE;
        else                     sweep_d = sweep_q + 10'd1;
      end

      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = sweep_q;
        wr_data_d = BLANK_GLYPH;
        if (sweep_q == LAST_ADDR) state_d = IDLE;
        else                      sweep_d = sweep_q + 10'd1;
      end

      default: begin
        sweep_d = '0;
        state_d = CLEAR;
      end
    endcase
  end

  // Reset lands in CLEAR so the screen is always blanked from address 0,
  // including when it interrupts a sweep already in progress.
  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q   <= CLEAR;
      row_q     <= '0;
      col_q     <= '0;
      scroll_q  <= '0;
      sweep_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      scroll_q  <= scroll_d;
      sweep_q   <= sweep_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.char_ready_out   = ready_q;
  assign bus.busy_out         = busy_q;
  assign bus.wr_en_out        = wr_en_q;
  assign bus.wr_addr_out      = wr_addr_q;
  assign bus.wr_data_out      = wr_data_q;
  assign bus.cursor_row_out   = row_q;
  assign bus.cursor_col_out   = col_q;
  assign bus.scroll_lines_out = scroll_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Bench for text_buffer_ctrl: a directed vector table, hand-written sweep and
// scroll sequences, and random traffic checked against a queue-based model.
module tb_text_buffer_ctrl;
  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  text_buffer_ctrl_if bus_if ();

  text_buffer_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: cursor/view as plain integers, pending blanking writes as a queue.
  int m_row, m_col, m_scroll;
  int pend[$];
  bit e_we, e_ready;
  int e_addr, e_data;

  typedef struct {
    bit valid; int ch; int sreq;
    bit we; int addr; int data;
    int row; int col; int scroll;
  } vec_t;
  vec_t vecs[23];

  bit r_valid;
  int r_sel, r_ch, r_sreq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int m_dist();
    return (m_row - m_scroll + 32) % 32;
  endfunction

  task automatic snap();
    if (m_dist() > 15) m_scroll = (m_row + 32 - 15) % 32;
  endtask

  task automatic enter_row();
    m_col = 0;
    m_row = (m_row + 1) % 32;
    snap();
    for (int c = 0; c < 32; c++) pend.push_back(m_row * 32 + c);
  endtask

  task automatic model_full_clear();
    pend.delete();
    for (int a = 0; a < 1024; a++) pend.push_back(a);
    m_row = 0; m_col = 0; m_scroll = 0;
  endtask

  task automatic model_edge(input bit v, input int ch, input int sr);
    e_we = 0;
    if (pend.size() != 0) begin
      e_we = 1; e_addr = pend.pop_front(); e_data = 26;
    end else if (v) begin
      if (ch <= 27) begin
        snap();
        e_we = 1; e_addr = m_row * 32 + m_col; e_data = ch;
        if (m_col == 31) enter_row();
        else m_col++;
      end else if (ch == 28) begin
        enter_row();
      end else if (ch == 29) begin
        snap();
        if (m_col > 0) begin
          m_col--; e_we = 1; e_addr = m_row * 32 + m_col; e_data = 26;
        end
      end else if (ch == 30) begin
        model_full_clear();
      end
    end else if (sr == 1) begin
      if (m_dist() > 15) m_scroll = (m_scroll + 1) % 32;
    end else if (sr == 2) begin
      if (m_dist() < 31) m_scroll = (m_scroll + 31) % 32;
    end
    e_ready = (pend.size() == 0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".ready"}, bus_if.char_ready_out, e_ready);
    check({tag, ".busy"},  bus_if.busy_out, !e_ready);
    check({tag, ".wr_en"}, bus_if.wr_en_out, e_we);
    if (e_we) begin
      check({tag, ".wr_addr"}, bus_if.wr_addr_out, e_addr);
      check({tag, ".wr_data"}, bus_if.wr_data_out, e_data);
    end
    check({tag, ".row"},    bus_if.cursor_row_out, m_row);
    check({tag, ".col"},    bus_if.cursor_col_out, m_col);
    check({tag, ".scroll"}, bus_if.scroll_lines_out, m_scroll);
  endtask

  task automatic step(input bit v, input int ch, input int sr, input string tag);
    bus_if.char_valid_in = v;
    bus_if.char_in       = 5'(ch);
    bus_if.scroll_req_in = 2'(sr);
    @(posedge clk_in);
    model_edge(v, ch, sr);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    bus_if.char_valid_in = 1'b0;
    bus_if.char_in       = '0;
    bus_if.scroll_req_in = '0;
    rst_in = 1'b1;
    @(posedge clk_in);
    model_full_clear();
    e_we = 0; e_ready = 0;
    #1;
    compare_model(tag);
    rst_in = 1'b0;
  endtask

  // n idle cycles that must each show one blanking write, ready rising only after the last.
  task automatic sweep_expect(input int base, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, tag);
      check({tag, ".sw_en"},    bus_if.wr_en_out, 1);
      check({tag, ".sw_addr"},  bus_if.wr_addr_out, base + i);
      check({tag, ".sw_data"},  bus_if.wr_data_out, 26);
      check({tag, ".sw_ready"}, bus_if.char_ready_out, (i == n - 1));
    end
  endtask

  initial begin
    // valid, ch, sreq,  we, addr, data,  row, col, scroll
    vecs[0]  = '{1'b1,  3, 0, 1'b1, 0,  3, 0, 1,  0};
    vecs[1]  = '{1'b1,  4, 0, 1'b1, 1,  4, 0, 2,  0};
    vecs[2]  = '{1'b1,  5, 0, 1'b1, 2,  5, 0, 3,  0};
    vecs[3]  = '{1'b0,  0, 0, 1'b0, 0,  0, 0, 3,  0};
    vecs[4]  = '{1'b1, 29, 0, 1'b1, 2, 26, 0, 2,  0};
    vecs[5]  = '{1'b1,  9, 0, 1'b1, 2,  9, 0, 3,  0};
    vecs[6]  = '{1'b1, 31, 0, 1'b0, 0,  0, 0, 3,  0};
    vecs[7]  = '{1'b0,  0, 1, 1'b0, 0,  0, 0, 3,  0};
    vecs[8]  = '{1'b0,  0, 2, 1'b0, 0,  0, 0, 3, 31};
    vecs[9]  = '{1'b1,  7, 1, 1'b1, 3,  7, 0, 4, 31};
    vecs[10] = '{1'b0,  0, 1, 1'b0, 0,  0, 0, 4, 31};
    vecs[11] = '{1'b0,  0, 3, 1'b0, 0,  0, 0, 4, 31};
    vecs[12] = '{1'b1, 29, 0, 1'b1, 3, 26, 0, 3, 31};
    vecs[13] = '{1'b1, 29, 0, 1'b1, 2, 26, 0, 2, 31};
    vecs[14] = '{1'b1, 29, 0, 1'b1, 1, 26, 0, 1, 31};
    vecs[15] = '{1'b1, 29, 0, 1'b1, 0, 26, 0, 0, 31};
    vecs[16] = '{1'b1, 29, 0, 1'b0, 0,  0, 0, 0, 31};
    vecs[17] = '{1'b1,  0, 0, 1'b1, 0,  0, 0, 1, 31};
    vecs[18] = '{1'b1,  1, 0, 1'b1, 1,  1, 0, 2, 31};
    vecs[19] = '{1'b1,  2, 0, 1'b1, 2,  2, 0, 3, 31};
    vecs[20] = '{1'b1, 27, 0, 1'b1, 3, 27, 0, 4, 31};
    vecs[21] = '{1'b1, 10, 0, 1'b1, 4, 10, 0, 5, 31};
    vecs[22] = '{1'b1, 29, 0, 1'b1, 4, 26, 0, 4, 31};

    do_reset("reset");
    check("reset.busy",  bus_if.busy_out, 1);
    check("reset.ready", bus_if.char_ready_out, 0);
    check("reset.wr_en", bus_if.wr_en_out, 0);
    check("reset.row",   bus_if.cursor_row_out, 0);
    check("reset.col",   bus_if.cursor_col_out, 0);
    sweep_expect(0, 1024, "init_clear");
    check("init_clear.busy", bus_if.busy_out, 0);

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].valid, vecs[i].ch, vecs[i].sreq, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.t_we", i), bus_if.wr_en_out, vecs[i].we);
      if (vecs[i].we) begin
        check($sformatf("vec%0d.t_addr", i), bus_if.wr_addr_out, vecs[i].addr);
        check($sformatf("vec%0d.t_data", i), bus_if.wr_data_out, vecs[i].data);
      end
      check($sformatf("vec%0d.t_row", i),    bus_if.cursor_row_out, vecs[i].row);
      check($sformatf("vec%0d.t_col", i),    bus_if.cursor_col_out, vecs[i].col);
      check($sformatf("vec%0d.t_scroll", i), bus_if.scroll_lines_out, vecs[i].scroll);
      check($sformatf("vec%0d.t_ready", i),  bus_if.char_ready_out, 1);
    end

    // Full row of glyphs wraps into a row clear, then a newline clears the next row.
    do_reset("wrap_rst");
    sweep_expect(0, 1024, "wrap_clear");
    for (int i = 0; i < 32; i++) step(1, i % 28, 0, "wrap_fill");
    check("wrap.last_addr", bus_if.wr_addr_out, 31);
    check("wrap.row",   bus_if.cursor_row_out, 1);
    check("wrap.col",   bus_if.cursor_col_out, 0);
    check("wrap.ready", bus_if.char_ready_out, 0);
    sweep_expect(32, 32, "wrap_row1");
    step(1, 28, 0, "wrap_nl");
    check("wrap_nl.wr_en", bus_if.wr_en_out, 0);
    sweep_expect(64, 32, "wrap_row2");
    check("wrap_end.row", bus_if.cursor_row_out, 2);
    check("wrap_end.col", bus_if.cursor_col_out, 0);

    // Auto-follow, manual scrolling limits, snap-back on typing, char beats scroll.
    do_reset("scr_rst");
    sweep_expect(0, 1024, "scr_clear");
    for (int r = 1; r <= 16; r++) begin
      step(1, 28, 0, "scr_nl");
      sweep_expect(r * 32, 32, "scr_rowclr");
    end
    check("scr.row16",   bus_if.cursor_row_out, 16);
    check("scr.follow",  bus_if.scroll_lines_out, 1);
    step(0, 0, 2, "scr_old1");  check("scr.old1",  bus_if.scroll_lines_out, 0);
    step(0, 0, 2, "scr_old2");  check("scr.old2",  bus_if.scroll_lines_out, 31);
    step(0, 0, 1, "scr_new1");  check("scr.new1",  bus_if.scroll_lines_out, 0);
    step(0, 0, 1, "scr_new2");  check("scr.new2",  bus_if.scroll_lines_out, 1);
    step(0, 0, 1, "scr_new3");  check("scr.new3",  bus_if.scroll_lines_out, 1);
    step(0, 0, 2, "scr_back1");
    step(0, 0, 2, "scr_back2"); check("scr.back",  bus_if.scroll_lines_out, 31);
    step(1, 5, 0, "scr_snap");
    check("scr.snap",      bus_if.scroll_lines_out, 1);
    check("scr.snap_addr", bus_if.wr_addr_out, 512);
    step(1, 6, 2, "scr_win");
    check("scr.win_scroll", bus_if.scroll_lines_out, 1);
    check("scr.win_col",    bus_if.cursor_col_out, 2);

    // Clear from (31,7), then reset in the middle of a clear sweep and of a row clear.
    do_reset("clr_rst");
    sweep_expect(0, 1024, "clr_init");
    for (int r = 1; r <= 31; r++) begin
      step(1, 28, 0, "clr_nl");
      sweep_expect(r * 32, 32, "clr_rowclr");
    end
    for (int i = 0; i < 7; i++) step(1, i, 0, "clr_glyph");
    check("clr.pre_row",    bus_if.cursor_row_out, 31);
    check("clr.pre_col",    bus_if.cursor_col_out, 7);
    check("clr.pre_scroll", bus_if.scroll_lines_out, 16);
    step(1, 30, 0, "clr_cmd");
    check("clr.row",    bus_if.cursor_row_out, 0);
    check("clr.col",    bus_if.cursor_col_out, 0);
    check("clr.scroll", bus_if.scroll_lines_out, 0);
    check("clr.wr_en",  bus_if.wr_en_out, 0);
    sweep_expect(0, 1024, "clr_sweep");
    step(1, 30, 0, "clr_cmd2");
    for (int i = 0; i <= 500; i++) step(0, 0, 0, "clr_part");
    check("clr.at500", bus_if.wr_addr_out, 500);
    do_reset("clr_abort");
    check("clr_abort.busy", bus_if.busy_out, 1);
    sweep_expect(0, 1024, "clr_restart");
    step(1, 28, 0, "rc_nl");
    for (int i = 0; i < 10; i++) step(0, 0, 0, "rc_part");
    do_reset("rc_abort");
    sweep_expect(0, 1024, "rc_restart");

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r_valid = ($urandom_range(0, 9) < 7);
      r_sel   = $urandom_range(0, 199);
      if (r_sel < 140)      r_ch = $urandom_range(0, 27);
      else if (r_sel < 165) r_ch = 28;
      else if (r_sel < 190) r_ch = 29;
      else if (r_sel < 199) r_ch = 31;
      else                  r_ch = ($urandom_range(0, 3) == 0) ? 30 : 31;
      r_sreq = $urandom_range(0, 3);
      step(r_valid, r_ch, r_sreq, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
